// File: rtl/cf_fft_1024_8_seq_pkg.sv
// cf_fft_1024_8_seq_pkg: shared state codes and counts for the 1024-point FFT frame sequencer.
package cf_fft_1024_8_seq_pkg;
  localparam int N = 1024;
  localparam int STAGES = 10;
  localparam logic [9:0] TERM_SAMP = 10'(N - 1);
  localparam logic [9:0] TERM_BFLY = 10'(N / 2 - 1);
  localparam logic [3:0] LAST_STAGE = 4'(STAGES - 1);
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_LOAD    = 3'b001,
    ST_SINIT   = 3'b010,
    ST_COMPUTE = 3'b011,
    ST_FLUSH   = 3'b100,
    ST_UNLOAD  = 3'b110,
    ST_DONE    = 3'b111
  } state_e;
endpackage

// File: rtl/cf_fft_1024_8_seq_cnt.sv
// cf_fft_1024_8_seq_cnt: 10-bit index counter that clears, or counts up and sticks at a terminal value.
module cf_fft_1024_8_seq_cnt (
  input  logic       clock_c,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [9:0] term_i,
  output logic [9:0] cnt_o
);
  logic [9:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (cnt_q == term_i) ? cnt_q : cnt_q + 10'd1;
  always_ff @(posedge clock_c)
    if (!reset_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/cf_fft_1024_8_seq.sv
// cf_fft_1024_8_seq: frame control sequencer stepping load, ten radix-2 stages, flush and unload.
module cf_fft_1024_8_seq
  import cf_fft_1024_8_seq_pkg::*;
(
  input  logic       clock_c,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       sync_i,
  input  logic       adv_i,
  output logic [2:0] state_o,
  output logic       load_done_o,
  output logic       stage_done_o,
  output logic       unload_done_o,
  output logic [3:0] stage_o,
  output logic [9:0] index_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       overrun_o
);
  state_e     state_q;
  logic [3:0] stage_q;
  logic       busy_q, frame_done_q, overrun_q;
  logic [9:0] idx;
  logic       cnt_st;
  // Every exit from a counting state is taken on adv_i, so adv_i alone marks the clear.
  assign cnt_st = state_q inside {ST_LOAD, ST_COMPUTE, ST_UNLOAD};
  cf_fft_1024_8_seq_cnt u_cnt (
    .clock_c(clock_c),
    .reset_i(reset_i),
    .en_i   (enable_i),
    .clr_i  (!cnt_st || adv_i),
    .term_i (state_q == ST_COMPUTE ? TERM_BFLY : TERM_SAMP),
    .cnt_o  (idx)
  );
  always_ff @(posedge clock_c)
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (enable_i) begin
      overrun_q    <= overrun_q || (sync_i && state_q != ST_IDLE);
      frame_done_q <= 1'b0;
      busy_q       <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          stage_q <= '0;
          busy_q  <= sync_i;
          if (sync_i) state_q <= ST_LOAD;
        end
        ST_LOAD:  if (adv_i) state_q <= ST_SINIT;
        ST_SINIT: state_q <= ST_COMPUTE;
        ST_COMPUTE: if (adv_i) begin
          state_q <= stage_q == LAST_STAGE ? ST_FLUSH : ST_SINIT;
          stage_q <= stage_q == LAST_STAGE ? 4'd0 : stage_q + 4'd1;
        end
        ST_FLUSH: state_q <= ST_UNLOAD;
        ST_UNLOAD: if (adv_i) begin
          state_q      <= ST_DONE;
          frame_done_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          stage_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  assign state_o       = state_q;
  assign stage_o       = stage_q;
  assign index_o       = idx;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;
  assign overrun_o     = overrun_q;
  assign load_done_o   = state_q == ST_LOAD    && idx == TERM_SAMP;
  assign stage_done_o  = state_q == ST_COMPUTE && idx == TERM_BFLY;
  assign unload_done_o = state_q == ST_UNLOAD  && idx == TERM_SAMP;
endmodule

// File: tb/tb_cf_fft_1024_8_seq.sv
// tb_cf_fft_1024_8_seq: scoreboard bench for the FFT frame sequencer with a looped-back condition selector.
module tb_cf_fft_1024_8_seq;
  logic       clock_c, reset_i, enable_i, sync_i, adv_i;
  logic [2:0] state_o;
  logic       load_done_o, stage_done_o, unload_done_o;
  logic [3:0] stage_o;
  logic [9:0] index_o;
  logic       busy_o, frame_done_o, overrun_o;
  cf_fft_1024_8_seq dut (
    .clock_c(clock_c), .reset_i(reset_i), .enable_i(enable_i), .sync_i(sync_i), .adv_i(adv_i),
    .state_o(state_o), .load_done_o(load_done_o), .stage_done_o(stage_done_o),
    .unload_done_o(unload_done_o), .stage_o(stage_o), .index_o(index_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .overrun_o(overrun_o)
  );
  typedef struct packed {
    logic [2:0] st;
    logic [9:0] idx;
    logic [3:0] stg;
    logic       ld, sd, ud, busy, fd, ovr;
  } obs_t;
  obs_t       sb[$];
  logic [2:0] m_st;
  logic [9:0] m_idx;
  logic [3:0] m_stg;
  logic       m_ovr;
  int         errors = 0, checks = 0, edges = 0;
  int         hist[8];
  logic [3:0] sinit_stg[$];
  logic [2:0] prev_st;
  logic [9:0] prev_idx, last_load_idx;
  int         gap_err;
  initial begin
    clock_c = 1'b0;
    forever #5 clock_c = ~clock_c;
  end
  function automatic obs_t dut_obs();
    return {state_o, index_o, stage_o, load_done_o, stage_done_o, unload_done_o, busy_o, frame_done_o, overrun_o};
  endfunction
  function automatic obs_t model_obs();
    obs_t o;
    o.st   = m_st;
    o.idx  = m_idx;
    o.stg  = m_stg;
    o.ld   = m_st == 3'b001 && m_idx == 10'd1023;
    o.sd   = m_st == 3'b011 && m_idx == 10'd511;
    o.ud   = m_st == 3'b110 && m_idx == 10'd1023;
    o.busy = m_st != 3'b000;
    o.fd   = m_st == 3'b111;
    o.ovr  = m_ovr;
    return o;
  endfunction
  task automatic model_step(input bit rst_n, input bit en, input bit sync, input bit adv);
    if (!rst_n) begin
      m_st = 3'b000; m_idx = '0; m_stg = '0; m_ovr = 1'b0;
    end else if (en) begin
      if (sync && m_st != 3'b000) m_ovr = 1'b1;
      case (m_st)
        3'b000: begin m_idx = '0; m_stg = '0; if (sync) m_st = 3'b001; end
        3'b001: if (adv) begin m_st = 3'b010; m_idx = '0; end else if (m_idx != 10'd1023) m_idx = m_idx + 10'd1;
        3'b010: begin m_st = 3'b011; m_idx = '0; end
        3'b011:
          if (adv) begin
            m_idx = '0;
            if (m_stg == 4'd9) begin m_stg = '0; m_st = 3'b100; end
            else begin m_stg = m_stg + 4'd1; m_st = 3'b010; end
          end else if (m_idx != 10'd511) m_idx = m_idx + 10'd1;
        3'b100: begin m_st = 3'b110; m_idx = '0; end
        3'b110: if (adv) begin m_st = 3'b111; m_idx = '0; end else if (m_idx != 10'd1023) m_idx = m_idx + 10'd1;
        default: begin m_st = 3'b000; m_idx = '0; end
      endcase
    end
  endtask
  // One clock: compare the previous prediction, drive inputs, predict, advance to the next negedge.
  task automatic cyc(input bit rst_n, input bit en, input bit sync, input bit hold);
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = dut_obs();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard edge %0d: observed %h required %h", edges, a, e);
      end
    end
    reset_i  = rst_n;
    enable_i = en;
    sync_i   = sync;
    adv_i    = (!rst_n || hold) ? 1'b0 :
               state_o == 3'b001 ? load_done_o :
               state_o == 3'b011 ? stage_done_o :
               state_o == 3'b110 ? unload_done_o : 1'b0;
    model_step(rst_n, en, sync, adv_i);
    sb.push_back(model_obs());
    @(posedge clock_c);
    edges++;
    @(negedge clock_c);
    hist[state_o]++;
    if (state_o == 3'b010) sinit_stg.push_back(stage_o);
    if (state_o == 3'b001) begin
      if (prev_st == 3'b001 && index_o != prev_idx && index_o != prev_idx + 10'd1) gap_err++;
      last_load_idx = index_o;
    end
    prev_st  = state_o;
    prev_idx = index_o;
  endtask
  task automatic clear_stats();
    for (int k = 0; k < 8; k++) hist[k] = 0;
    sinit_stg.delete();
    gap_err = 0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (state_o !== 3'b000 || index_o !== 10'd0 || stage_o !== 4'd0 || overrun_o !== 1'b0 ||
        busy_o !== 1'b0 || frame_done_o !== 1'b0 || {load_done_o, stage_done_o, unload_done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset: state=%b idx=%0d stage=%0d ovr=%b busy=%b fd=%b flags=%b required all zero",
               state_o, index_o, stage_o, overrun_o, busy_o, frame_done_o, {load_done_o, stage_done_o, unload_done_o});
    end
  endtask
  task automatic test_full_frame();
    int e0, n;
    bit ok;
    clear_stats();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    e0 = edges;
    n = 0;
    while (frame_done_o !== 1'b1 && n < 8000) begin cyc(1'b1, 1'b1, 1'b0, 1'b0); n++; end
    checks++;
    if (edges - e0 != 7179) begin errors++; $display("FAIL frame_done_edge: observed %0d required 7179", edges - e0); end
    checks++;
    if (hist[1] != 1024) begin errors++; $display("FAIL load_cycles: observed %0d required 1024", hist[1]); end
    checks++;
    if (hist[2] != 10 || hist[3] != 5120) begin
      errors++; $display("FAIL compute_cycles: sinit=%0d compute=%0d required 10 and 5120", hist[2], hist[3]);
    end
    checks++;
    if (hist[4] != 1 || hist[6] != 1024) begin
      errors++; $display("FAIL flush_unload: flush=%0d unload=%0d required 1 and 1024", hist[4], hist[6]);
    end
    ok = sinit_stg.size() == 10;
    for (int i = 0; i < sinit_stg.size(); i++) if (sinit_stg[i] != 4'(i)) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stage_sequence: observed %p required 0..9", sinit_stg); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state_o !== 3'b000 || edges - e0 != 7180) begin
      errors++; $display("FAIL idle_return: state=%b at edge %0d required 000 at 7180", state_o, edges - e0);
    end
  endtask
  task automatic test_stall();
    int n;
    clear_stats();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (state_o === 3'b001 && n < 5000) begin cyc(1'b1, n[0], 1'b0, 1'b0); n++; end
    checks++;
    if (hist[1] != 2048) begin errors++; $display("FAIL stall_load_cycles: observed %0d required 2048", hist[1]); end
    checks++;
    if (gap_err != 0 || last_load_idx !== 10'd1023) begin
      errors++; $display("FAIL stall_index: gaps=%0d last=%0d required 0 and 1023", gap_err, last_load_idx);
    end
    n = 0;
    while (state_o !== 3'b000 && n < 8000) begin cyc(1'b1, 1'b1, 1'b0, 1'b0); n++; end
    checks++;
    if (state_o !== 3'b000) begin errors++; $display("FAIL stall_finish: state=%b required 000", state_o); end
  endtask
  task automatic test_withheld_overrun();
    int n;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!(state_o === 3'b011 && stage_o === 4'd3 && index_o === 10'd511) && n < 4000) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0); n++;
    end
    checks++;
    if (n >= 4000) begin errors++; $display("FAIL reach_stage3: state=%b stage=%0d idx=%0d required 011/3/511", state_o, stage_o, index_o); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (state_o !== 3'b011 || index_o !== 10'd511 || stage_done_o !== 1'b1) begin
        errors++; $display("FAIL withheld_hold: state=%b idx=%0d sd=%b required 011/511/1", state_o, index_o, stage_done_o);
      end
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state_o !== 3'b010 || stage_o !== 4'd4) begin
      errors++; $display("FAIL withheld_release: state=%b stage=%0d required 010/4", state_o, stage_o);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (overrun_o !== 1'b1 || state_o !== 3'b011) begin
      errors++; $display("FAIL overrun_set: ovr=%b state=%b required 1/011", overrun_o, state_o);
    end
    n = 0;
    while (state_o !== 3'b111 && n < 8000) begin cyc(1'b1, 1'b1, 1'b0, 1'b0); n++; end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (state_o !== 3'b000 || overrun_o !== 1'b1) begin
      errors++; $display("FAIL sync_in_done: state=%b ovr=%b required 000/1", state_o, overrun_o);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state_o !== 3'b000 || overrun_o !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: state=%b ovr=%b required 000/1", state_o, overrun_o);
    end
  endtask
  task automatic test_mid_reset();
    int n;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!(state_o === 3'b110 && index_o === 10'd200) && n < 8000) begin cyc(1'b1, 1'b1, 1'b0, 1'b0); n++; end
    checks++;
    if (n >= 8000) begin errors++; $display("FAIL reach_unload200: state=%b idx=%0d required 110/200", state_o, index_o); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state_o !== 3'b000 || index_o !== 10'd0 || stage_o !== 4'd0 || overrun_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset: state=%b idx=%0d stage=%0d ovr=%b busy=%b required all zero",
                         state_o, index_o, stage_o, overrun_o, busy_o);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state_o !== 3'b000) begin errors++; $display("FAIL no_auto_start: state=%b required 000", state_o); end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (state_o !== 3'b001 || index_o !== 10'd0) begin
      errors++; $display("FAIL restart: state=%b idx=%0d required 001/0", state_o, index_o);
    end
  endtask
  initial begin
    obs_t e, a;
    reset_i = 1'b0; enable_i = 1'b0; sync_i = 1'b0; adv_i = 1'b0;
    prev_st = 3'b000; prev_idx = '0; last_load_idx = '0;
    m_st = 3'b000; m_idx = '0; m_stg = '0; m_ovr = 1'b0;
    clear_stats();
    test_reset();
    test_full_frame();
    test_stall();
    test_withheld_overrun();
    test_mid_reset();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = dut_obs();
      checks++;
      if (a !== e) begin errors++; $display("FAIL scoreboard_final: observed %h required %h", a, e); end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cf_fft_1024_8_seq.md
# cf_fft_1024_8_seq

Frame control sequencer for the 1024-point, 8-bit FFT core. It owns the 3-bit control-state register and drives it onto the state bus consumed by the datapath condition selector. It generates the per-state completion flags that feed that selector and consumes the selected advance bit to move through load, ten radix-2 stages, flush and unload. It also emits the sample/butterfly index, stage number and frame status.

## Interface
- N, 1024, transform length (fixed; only 1024 supported)
- STAGES, 10, log2(N)
- clock_c  in  1  sole clock, rising edge
- reset_i  in  1  synchronous, active-low reset
- enable_i  in  1  global clock enable; when low, no register changes
- sync_i  in  1  frame start request, sampled in IDLE only
- adv_i  in  1  advance bit returned by the condition selector
- state_o  out  3  current control-state code (drives selector)
- load_done_o  out  1  load-complete flag (selector input for code 001)
- stage_done_o  out  1  stage-complete flag (selector input for code 011)
- unload_done_o  out  1  unload-complete flag (selector input for code 110)
- stage_o  out  4  current FFT stage, 0..9
- index_o  out  10  sample index (LOAD/UNLOAD) or butterfly index (COMPUTE)
- busy_o  out  1  high in every state except IDLE
- frame_done_o  out  1  one-cycle pulse in DONE
- overrun_o  out  1  sticky: sync_i seen while not IDLE

## Operation
- All registers update only on enabled edges; reset_i low forces IDLE and zeroes every counter and output, including the sticky overrun_o, regardless of enable_i.
- States (code): IDLE 000, LOAD 001, SINIT 010, COMPUTE 011, FLUSH 100, UNLOAD 110, DONE 111. Code 101 is illegal and goes to IDLE on the next enabled edge.
- IDLE: index and stage are 0. On sync_i go to LOAD. adv_i is ignored.
- LOAD: index increments 0..1023. load_done_o = (index==1023). On adv_i go to SINIT, index to 0.
- SINIT: one cycle; index to 0; go to COMPUTE unconditionally.
- COMPUTE: index increments 0..511. stage_done_o = (index==511).
  - On adv_i with stage<9: stage+1, go to SINIT.
  - On adv_i with stage==9: stage to 0, go to FLUSH.
- FLUSH: one cycle; go to UNLOAD.
- UNLOAD: index increments 0..1023. unload_done_o = (index==1023). On adv_i go to DONE.
- DONE: frame_done_o=1 for one cycle; go to IDLE. sync_i here is an overrun and does not start a frame.
- Done flags are combinational from the registered state and index; each is 0 outside its own state.
- adv_i is sampled only in LOAD, COMPUTE and UNLOAD.
- If adv_i is low at a terminal index, the index holds at its terminal value and the state holds.
- overrun_o sets on an enabled edge where sync_i=1 and state≠IDLE.

## Timing
- state_o, stage_o, index_o, busy_o, frame_done_o and overrun_o are registered.
- Done flags are combinational, so the selector's adv_i is valid in the same cycle; no combinational path from adv_i to any output.
- With enable_i and a correctly wired selector constantly high:
  - LOAD lasts 1024 cycles.
  - Each stage lasts 513 cycles (SINIT + 512).
  - FLUSH lasts 1 cycle; UNLOAD lasts 1024; DONE lasts 1.
  - frame_done_o rises 7179 edges after the edge that samples sync_i.
  - IDLE is re-entered at edge 7180.
- enable_i low stretches every state cycle-for-cycle with no loss of index.
- Reset asserted mid-frame returns to IDLE on that edge. The next frame needs a fresh sync_i.

## Structure
- Shared package holds:
  - the state-code constants (ST_IDLE..ST_DONE, 3-bit);
  - N, STAGES;
  - the terminal counts 1023 and 511.
- One natural sub-module, cf_fft_1024_8_seq_cnt: a 10-bit index counter with enable, clear and an increment-saturate-at-terminal input. The terminal value is selected by state.

## Test plan
- Reset: hold reset_i=0 for 3 edges with sync_i=1 -> state_o=000, index_o=0, stage_o=0, all flags 0, overrun_o=0.
- Full frame (enable_i=1, adv_i looped from the done flags):
  - sync_i pulse -> state_o=001 for 1024 cycles;
  - ten 010/011 passes with stage_o 0..9;
  - FLUSH, then UNLOAD for 1024 cycles;
  - frame_done_o high exactly at edge 7179; IDLE at 7180.
- Stall: toggle enable_i 50% during LOAD -> LOAD lasts 2048 cycles; index_o sequence is unchanged and gap-free.
- Withheld advance: hold adv_i=0 in COMPUTE stage 3 -> index_o holds at 511 and stage_done_o holds at 1. Releasing adv_i gives SINIT with stage_o=4.
- Overrun: sync_i=1 in COMPUTE -> overrun_o=1, which stays set after DONE/IDLE until reset.
- Mid-frame reset: reset_i=0 in UNLOAD at index 200 -> the next edge gives IDLE, index 0. A frame starts only on a new sync_i.
